// File: rtl/sm3_feeder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : sm3_feeder_pkg                                               |
// | Description : Shared constants, FSM state encoding and the byte-placement  |
// |               helper for the SM3 message feeder.                           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package sm3_feeder_pkg;

    // Word width of the SM3 core message interface (fixed).
    localparam int unsigned c_WIDTH  = 32;
    // Byte index within a word: 0 selects [31:24], 3 selects [7:0].
    localparam int unsigned c_BIDX_W = 2;
    // last_word_byte encoding used when the final word is completely filled.
    localparam logic [c_BIDX_W-1:0] c_LWB_FULL = 2'd0;

    // Feeder FSM state encoding.
    typedef logic [1:0] state_t;
    localparam state_t c_ST_IDLE      = 2'd0;
    localparam state_t c_ST_FILL      = 2'd1;
    localparam state_t c_ST_DRAIN     = 2'd2;
    localparam state_t c_ST_WAIT_DONE = 2'd3;

    // Drop byte b into word at big-endian position idx; other bytes untouched.
    function automatic logic [c_WIDTH-1:0] place_byte(
        input logic [c_WIDTH-1:0]  word,
        input logic [7:0]          b,
        input logic [c_BIDX_W-1:0] idx
    );
        logic [c_WIDTH-1:0] r;
        r = word;
        case (idx)
            2'd0:    r[31:24] = b;
            2'd1:    r[23:16] = b;
            2'd2:    r[15:8]  = b;
            default: r[7:0]   = b;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sm3_word_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sm3_word_fifo                                                |
// | Description : Synchronous FIFO holding packed message words together with  |
// |               their last-word flag and byte count.                         |
// |   clk_in, reset_in : clock, synchronous active-high reset                  |
// |   i_wr_en/i_wr_data: push request and entry                                |
// |   i_rd_en          : pop request (head is o_rd_data)                       |
// |   o_full/o_empty/o_count : occupancy status                                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sm3_word_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 35,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk_in,
    input  logic              reset_in,
    input  logic              i_wr_en,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_full,
    output logic              o_empty,
    output logic [CNT_W-1:0]  o_count
);

    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] c_PTR_ONE = PTR_W'(1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_do_wr;
    logic              w_do_rd;

    assign o_full  = (r_count == c_CNT_MAX);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

    assign w_do_rd = i_rd_en & ~o_empty;
    // A push while full is allowed when the head leaves in the same cycle.
    assign w_do_wr = i_wr_en & (~o_full | w_do_rd);

    assign o_rd_data = r_mem[r_rd_ptr];

    always_ff @(posedge clk_in) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_do_rd) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_do_wr, w_do_rd})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/sm3_msg_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sm3_msg_feeder                                               |
// | Description : Byte-stream front end for the SM3 hash core. Packs bytes     |
// |               big-endian into 32-bit words, queues them and drives the     |
// |               core word interface and enable level for one message.        |
// |   clk_in, reset_in          : clock, synchronous active-high reset         |
// |   byte_in/valid/last/ready  : byte input handshake                         |
// |   msg_out/valid/ready       : word output handshake (FIFO head)            |
// |   is_last_word_out, last_word_byte_out : final-word marking                |
// |   sm3_en_out, sm3_finished_in : core enable / finished levels              |
// |   busy_out, msg_len_out     : status                                       |
// | Option      : SM3_FEEDER_LEN_CNT_EN enables the saturating byte counter    |
// |               on msg_len_out; otherwise msg_len_out is 0.                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sm3_msg_feeder
    import sm3_feeder_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int WIDTH      = c_WIDTH
) (
    input  logic                clk_in,
    input  logic                reset_in,
    input  logic [7:0]          byte_in,
    input  logic                byte_valid_in,
    input  logic                byte_last_in,
    output logic                byte_ready_out,
    output logic [WIDTH-1:0]    msg_out,
    output logic                msg_valid_out,
    input  logic                msg_ready_in,
    output logic                is_last_word_out,
    output logic [c_BIDX_W-1:0] last_word_byte_out,
    output logic                sm3_en_out,
    input  logic                sm3_finished_in,
    output logic                busy_out,
    output logic [31:0]         msg_len_out
);

    localparam int ENTRY_W = WIDTH + 1 + c_BIDX_W;
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;

    state_t              r_state;
    logic [c_BIDX_W-1:0] r_idx;
    logic [WIDTH-1:0]    r_word;
    logic                r_en;
    logic                r_fin_q;

    logic                w_state_rx;
    logic                w_push_pending;
    logic                w_accept;
    logic                w_push;
    logic                w_pop;
    logic                w_fin_rise;
    logic [WIDTH-1:0]    w_word_next;
    logic [c_BIDX_W-1:0] w_lwb;
    logic [ENTRY_W-1:0]  w_wr_data;
    logic [ENTRY_W-1:0]  w_head;
    logic                w_full;
    logic                w_empty;
    logic [CNT_W-1:0]    w_count;

    assign w_state_rx = (r_state == c_ST_IDLE) | (r_state == c_ST_FILL);
    // The byte on offer would complete a word (index wraps or message ends).
    assign w_push_pending = byte_valid_in & ((r_idx == 2'd3) | byte_last_in);
    assign byte_ready_out = w_state_rx & ~(w_full & w_push_pending);

    assign w_accept    = byte_valid_in & byte_ready_out;
    assign w_push      = w_accept & ((r_idx == 2'd3) | byte_last_in);
    assign w_word_next = place_byte(r_word, byte_in, r_idx);
    // Total accepted bytes mod 4 equals the index after this byte.
    assign w_lwb       = r_idx + 2'd1;
    assign w_wr_data   = {byte_last_in, (byte_last_in ? w_lwb : c_LWB_FULL), w_word_next};

    assign w_pop      = msg_valid_out & msg_ready_in;
    assign w_fin_rise = sm3_finished_in & ~r_fin_q;

    sm3_word_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (ENTRY_W)
    ) u_fifo (
        .clk_in    (clk_in),
        .reset_in  (reset_in),
        .i_wr_en   (w_push),
        .i_wr_data (w_wr_data),
        .i_rd_en   (w_pop),
        .o_rd_data (w_head),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_count   (w_count)
    );

    // Head fields are forced to zero while empty so the outputs are defined.
    assign msg_valid_out      = (w_count != '0);
    assign msg_out            = w_empty ? '0 : w_head[WIDTH-1:0];
    assign last_word_byte_out = w_empty ? '0 : w_head[WIDTH+c_BIDX_W-1:WIDTH];
    assign is_last_word_out   = w_empty ? 1'b0 : w_head[ENTRY_W-1];

    assign sm3_en_out = r_en;
    assign busy_out   = (r_state != c_ST_IDLE);

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_state <= c_ST_IDLE;
            r_idx   <= '0;
            r_word  <= '0;
            r_en    <= 1'b0;
            r_fin_q <= 1'b0;
        end else begin
            r_fin_q <= sm3_finished_in;

            if (w_accept) begin
                if (w_push) begin
                    r_word <= '0;
                    r_idx  <= '0;
                end else begin
                    r_word <= w_word_next;
                    r_idx  <= r_idx + 2'd1;
                end
            end

            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        r_en    <= 1'b1;
                        // A single-byte message has nothing left to fill.
                        r_state <= byte_last_in ? c_ST_DRAIN : c_ST_FILL;
                    end
                end
                c_ST_FILL: begin
                    if (w_accept & byte_last_in) begin
                        r_state <= c_ST_DRAIN;
                    end
                end
                c_ST_DRAIN: begin
                    if (w_pop & is_last_word_out) begin
                        r_state <= c_ST_WAIT_DONE;
                    end
                end
                c_ST_WAIT_DONE: begin
                    // Only a fresh rise counts; a level left high is ignored.
                    if (w_fin_rise) begin
                        r_en    <= 1'b0;
                        r_state <= c_ST_IDLE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

`ifdef SM3_FEEDER_LEN_CNT_EN
    logic [31:0] r_len;

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_len <= '0;
        end else if (w_accept) begin
            if (r_state == c_ST_IDLE) begin
                r_len <= 32'd1;
            end else if (r_len != 32'hFFFF_FFFF) begin
                r_len <= r_len + 32'd1;
            end
        end
    end

    assign msg_len_out = r_len;
`else
    assign msg_len_out = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sm3_msg_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_sm3_msg_feeder                                            |
// | Description : Self-checking bench for sm3_msg_feeder. Messages are built   |
// |               as byte lists; the expected word stream is derived from the  |
// |               byte lists by chunking into big-endian groups of four.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_sm3_msg_feeder;

    logic        clk_in = 1'b0;
    logic        reset_in;
    logic [7:0]  byte_in;
    logic        byte_valid_in;
    logic        byte_last_in;
    logic        byte_ready_out;
    logic [31:0] msg_out;
    logic        msg_valid_out;
    logic        msg_ready_in;
    logic        is_last_word_out;
    logic [1:0]  last_word_byte_out;
    logic        sm3_en_out;
    logic        sm3_finished_in;
    logic        busy_out;
    logic [31:0] msg_len_out;

    sm3_msg_feeder #(.FIFO_DEPTH(4), .WIDTH(32)) dut (
        .clk_in             (clk_in),
        .reset_in           (reset_in),
        .byte_in            (byte_in),
        .byte_valid_in      (byte_valid_in),
        .byte_last_in       (byte_last_in),
        .byte_ready_out     (byte_ready_out),
        .msg_out            (msg_out),
        .msg_valid_out      (msg_valid_out),
        .msg_ready_in       (msg_ready_in),
        .is_last_word_out   (is_last_word_out),
        .last_word_byte_out (last_word_byte_out),
        .sm3_en_out         (sm3_en_out),
        .sm3_finished_in    (sm3_finished_in),
        .busy_out           (busy_out),
        .msg_len_out        (msg_len_out)
    );

    always #5 clk_in = ~clk_in;

`ifdef SM3_FEEDER_LEN_CNT_EN
    localparam logic [31:0] LEN_MASK = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] LEN_MASK = 32'h0;
`endif

    typedef struct packed {
        logic [31:0] w;
        logic        last;
        logic [1:0]  lwb;
    } word_t;

    word_t      got_q[$];
    word_t      exp_q[$];
    logic [7:0] msg_b[$];
    int         n_cmp  = 0;
    int         n_fail = 0;
    int         cyc    = 0;
    bit         rand_bp = 1'b0;

    always @(posedge clk_in) cyc++;

    // A word seen valid+ready here leaves the DUT at the next rising edge.
    always @(negedge clk_in) begin
        if (!reset_in && msg_valid_out && msg_ready_in)
            got_q.push_back({msg_out, is_last_word_out, last_word_byte_out});
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
        if (rand_bp) msg_ready_in = 1'($urandom_range(0, 1));
    endtask

    // Expected words: consecutive groups of four bytes, first byte in the MSBs.
    task automatic model_msg();
        int n;
        n = msg_b.size();
        for (int i = 0; i < n; i += 4) begin
            word_t e;
            e.w = 32'h0;
            for (int k = 0; k < 4; k++)
                if (i + k < n) e.w[31-8*k -: 8] = msg_b[i+k];
            e.last = (i + 4 >= n);
            e.lwb  = e.last ? 2'(n % 4) : 2'd0;
            exp_q.push_back(e);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        int w;
        w = 0;
        byte_in = b; byte_last_in = last; byte_valid_in = 1'b1;
        #1;
        while (!byte_ready_out && w < 300) begin tick(); #1; w++; end
        if (!byte_ready_out) begin
            n_cmp++; n_fail++;
            $display("FAIL send_byte_timeout: byte_ready_out=%b required 1", byte_ready_out);
        end
        tick();
        byte_valid_in = 1'b0; byte_last_in = 1'b0;
    endtask

    task automatic send_msg();
        for (int i = 0; i < msg_b.size(); i++) send_byte(msg_b[i], i == msg_b.size() - 1);
    endtask

    task automatic wait_words(input int n);
        int w;
        w = 0;
        while (got_q.size() < n && w < 600) begin tick(); w++; end
        if (got_q.size() < n) begin
            n_cmp++; n_fail++;
            $display("FAIL wait_words_timeout: got %0d words required %0d", got_q.size(), n);
        end
    endtask

    task automatic pulse_finished();
        sm3_finished_in = 1'b1;
        tick();
        sm3_finished_in = 1'b0;
    endtask

    task automatic clear_all();
        got_q.delete(); exp_q.delete(); msg_b.delete();
    endtask

    task automatic test_reset();
        reset_in = 1'b1;
        repeat (3) tick();
        reset_in = 1'b0;
        #1;
        n_cmp++; if (byte_ready_out !== 1'b1) begin n_fail++; $display("FAIL rst_byte_ready: got %b required 1", byte_ready_out); end
        n_cmp++; if (msg_valid_out !== 1'b0) begin n_fail++; $display("FAIL rst_msg_valid: got %b required 0", msg_valid_out); end
        n_cmp++; if (msg_out !== 32'h0) begin n_fail++; $display("FAIL rst_msg_out: got %h required 0", msg_out); end
        n_cmp++; if (is_last_word_out !== 1'b0) begin n_fail++; $display("FAIL rst_is_last: got %b required 0", is_last_word_out); end
        n_cmp++; if (last_word_byte_out !== 2'd0) begin n_fail++; $display("FAIL rst_lwb: got %0d required 0", last_word_byte_out); end
        n_cmp++; if (sm3_en_out !== 1'b0) begin n_fail++; $display("FAIL rst_en: got %b required 0", sm3_en_out); end
        n_cmp++; if (busy_out !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b required 0", busy_out); end
        n_cmp++; if (msg_len_out !== 32'h0) begin n_fail++; $display("FAIL rst_len: got %h required 0", msg_len_out); end
    endtask

    task automatic test_abc();
        clear_all();
        msg_ready_in = 1'b1;
        msg_b = '{8'h61, 8'h62, 8'h63};
        model_msg();
        send_byte(8'h61, 1'b0);
        n_cmp++; if (sm3_en_out !== 1'b1) begin n_fail++; $display("FAIL abc_en_rise: got %b required 1", sm3_en_out); end
        send_byte(8'h62, 1'b0);
        send_byte(8'h63, 1'b1);
        n_cmp++; if (msg_valid_out !== 1'b1 || msg_out !== 32'h61626300 || is_last_word_out !== 1'b1 || last_word_byte_out !== 2'd3) begin
            n_fail++; $display("FAIL abc_head: got v=%b %h last=%b lwb=%0d required v=1 61626300 last=1 lwb=3", msg_valid_out, msg_out, is_last_word_out, last_word_byte_out);
        end
        wait_words(exp_q.size());
        n_cmp++; if (busy_out !== 1'b1 || sm3_en_out !== 1'b1) begin n_fail++; $display("FAIL abc_wait_done: got busy=%b en=%b required 1/1", busy_out, sm3_en_out); end
        n_cmp++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL abc_count: got %0d words required %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i].w !== exp_q[i].w || got_q[i].last !== exp_q[i].last || (exp_q[i].last && got_q[i].lwb !== exp_q[i].lwb)) begin
                n_fail++; $display("FAIL abc_word%0d: got %h/%b/%0d required %h/%b/%0d", i, got_q[i].w, got_q[i].last, got_q[i].lwb, exp_q[i].w, exp_q[i].last, exp_q[i].lwb);
            end
        end
        n_cmp++; if (msg_len_out !== (32'd3 & LEN_MASK)) begin n_fail++; $display("FAIL abc_len: got %0d required %0d", msg_len_out, 32'd3 & LEN_MASK); end
        pulse_finished();
        n_cmp++; if (busy_out !== 1'b0 || sm3_en_out !== 1'b0) begin n_fail++; $display("FAIL abc_idle: got busy=%b en=%b required 0/0", busy_out, sm3_en_out); end
    endtask

    task automatic test_eight();
        clear_all();
        msg_ready_in = 1'b1;
        for (int i = 0; i < 8; i++) msg_b.push_back(8'(i));
        model_msg();
        send_msg();
        wait_words(exp_q.size());
        n_cmp++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL eight_count: got %0d words required %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i].w !== exp_q[i].w || got_q[i].last !== exp_q[i].last || (exp_q[i].last && got_q[i].lwb !== exp_q[i].lwb)) begin
                n_fail++; $display("FAIL eight_word%0d: got %h/%b/%0d required %h/%b/%0d", i, got_q[i].w, got_q[i].last, got_q[i].lwb, exp_q[i].w, exp_q[i].last, exp_q[i].lwb);
            end
        end
        n_cmp++; if (msg_len_out !== (32'd8 & LEN_MASK)) begin n_fail++; $display("FAIL eight_len: got %0d required %0d", msg_len_out, 32'd8 & LEN_MASK); end
        pulse_finished();
    endtask

    task automatic test_backpressure();
        int first_block;
        int w;
        clear_all();
        msg_ready_in = 1'b0;
        first_block = -1;
        for (int i = 0; i < 24; i++) msg_b.push_back(8'(i * 7 + 3));
        model_msg();
        for (int i = 0; i < 24; i++) begin
            byte_in = msg_b[i]; byte_last_in = (i == 23); byte_valid_in = 1'b1;
            #1;
            if (!byte_ready_out && first_block < 0) begin
                first_block = i;
                repeat (3) tick();
                #1;
                n_cmp++; if (byte_ready_out !== 1'b0) begin n_fail++; $display("FAIL bp_hold: byte_ready_out=%b required 0", byte_ready_out); end
                n_cmp++; if (got_q.size() != 0) begin n_fail++; $display("FAIL bp_no_pop: got %0d words required 0", got_q.size()); end
                msg_ready_in = 1'b1;
            end
            w = 0;
            while (!byte_ready_out && w < 100) begin tick(); #1; w++; end
            tick();
        end
        byte_valid_in = 1'b0; byte_last_in = 1'b0;
        n_cmp++; if (first_block != 19) begin n_fail++; $display("FAIL bp_block_point: got byte %0d required 19", first_block); end
        wait_words(exp_q.size());
        n_cmp++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL bp_count: got %0d words required %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i].w !== exp_q[i].w || got_q[i].last !== exp_q[i].last || (exp_q[i].last && got_q[i].lwb !== exp_q[i].lwb)) begin
                n_fail++; $display("FAIL bp_word%0d: got %h/%b/%0d required %h/%b/%0d", i, got_q[i].w, got_q[i].last, got_q[i].lwb, exp_q[i].w, exp_q[i].last, exp_q[i].lwb);
            end
        end
        pulse_finished();
    endtask

    task automatic test_sticky_finished();
        clear_all();
        msg_ready_in = 1'b1;
        msg_b = '{8'h11, 8'h22};
        model_msg();
        send_msg();
        wait_words(exp_q.size());
        sm3_finished_in = 1'b1;
        tick();
        n_cmp++; if (busy_out !== 1'b0) begin n_fail++; $display("FAIL sticky_first_done: busy=%b required 0", busy_out); end
        clear_all();
        for (int i = 0; i < 5; i++) msg_b.push_back(8'($urandom));
        model_msg();
        send_msg();
        wait_words(exp_q.size());
        repeat (4) tick();
        n_cmp++; if (busy_out !== 1'b1 || sm3_en_out !== 1'b1) begin n_fail++; $display("FAIL sticky_no_early_idle: busy=%b en=%b required 1/1", busy_out, sm3_en_out); end
        sm3_finished_in = 1'b0;
        tick();
        n_cmp++; if (busy_out !== 1'b1) begin n_fail++; $display("FAIL sticky_fall: busy=%b required 1", busy_out); end
        sm3_finished_in = 1'b1;
        tick();
        n_cmp++; if (busy_out !== 1'b0 || sm3_en_out !== 1'b0) begin n_fail++; $display("FAIL sticky_rise: busy=%b en=%b required 0/0", busy_out, sm3_en_out); end
        sm3_finished_in = 1'b0;
        n_cmp++; if (got_q.size() != exp_q.size() || (got_q.size() > 1 && got_q[1].w !== exp_q[1].w)) begin
            n_fail++; $display("FAIL sticky_words: got %0d words required %0d", got_q.size(), exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        clear_all();
        msg_ready_in = 1'b0;
        for (int i = 0; i < 5; i++) send_byte(8'(8'hA0 + i), 1'b0);
        reset_in = 1'b1;
        tick();
        reset_in = 1'b0;
        #1;
        n_cmp++; if (msg_valid_out !== 1'b0 || sm3_en_out !== 1'b0 || byte_ready_out !== 1'b1 || busy_out !== 1'b0) begin
            n_fail++; $display("FAIL midrst_state: valid=%b en=%b ready=%b busy=%b required 0/0/1/0", msg_valid_out, sm3_en_out, byte_ready_out, busy_out);
        end
        clear_all();
        msg_ready_in = 1'b1;
        msg_b = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        model_msg();
        send_msg();
        wait_words(exp_q.size());
        repeat (3) tick();
        n_cmp++; if (got_q.size() != 1) begin n_fail++; $display("FAIL midrst_count: got %0d words required 1", got_q.size()); end
        n_cmp++; if (got_q.size() < 1 || got_q[0].w !== 32'hDEADBEEF || got_q[0].last !== 1'b1 || got_q[0].lwb !== 2'd0) begin
            n_fail++; $display("FAIL midrst_word: got %h required deadbeef/last/0", (got_q.size() > 0) ? got_q[0].w : 32'h0);
        end
        n_cmp++; if (msg_len_out !== (32'd4 & LEN_MASK)) begin n_fail++; $display("FAIL midrst_len: got %0d required %0d", msg_len_out, 32'd4 & LEN_MASK); end
        pulse_finished();
    endtask

    task automatic test_drain_block();
        clear_all();
        msg_ready_in = 1'b0;
        msg_b = '{8'h01, 8'h02, 8'h03};
        model_msg();
        send_msg();
        msg_b = '{8'hA5};
        model_msg();
        byte_in = 8'hA5; byte_last_in = 1'b1; byte_valid_in = 1'b1;
        #1;
        n_cmp++; if (byte_ready_out !== 1'b0) begin n_fail++; $display("FAIL drain_ready: got %b required 0", byte_ready_out); end
        tick(); tick();
        #1;
        n_cmp++; if (byte_ready_out !== 1'b0) begin n_fail++; $display("FAIL drain_ready_hold: got %b required 0", byte_ready_out); end
        msg_ready_in = 1'b1;
        tick();
        #1;
        n_cmp++; if (byte_ready_out !== 1'b0 || busy_out !== 1'b1 || got_q.size() != 1) begin
            n_fail++; $display("FAIL wait_done_ready: ready=%b busy=%b words=%0d required 0/1/1", byte_ready_out, busy_out, got_q.size());
        end
        sm3_finished_in = 1'b1;
        tick();
        sm3_finished_in = 1'b0;
        #1;
        n_cmp++; if (byte_ready_out !== 1'b1 || busy_out !== 1'b0) begin n_fail++; $display("FAIL idle_accept: ready=%b busy=%b required 1/0", byte_ready_out, busy_out); end
        tick();
        byte_valid_in = 1'b0; byte_last_in = 1'b0;
        wait_words(exp_q.size());
        n_cmp++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL drain_count: got %0d words required %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i].w !== exp_q[i].w || got_q[i].last !== exp_q[i].last || (exp_q[i].last && got_q[i].lwb !== exp_q[i].lwb)) begin
                n_fail++; $display("FAIL drain_word%0d: got %h/%b/%0d required %h/%b/%0d", i, got_q[i].w, got_q[i].last, got_q[i].lwb, exp_q[i].w, exp_q[i].last, exp_q[i].lwb);
            end
        end
        pulse_finished();
    endtask

    task automatic test_back_to_back();
        int t0;
        clear_all();
        msg_ready_in = 1'b1;
        for (int i = 0; i < 16; i++) msg_b.push_back(8'($urandom));
        model_msg();
        t0 = cyc;
        send_msg();
        n_cmp++; if (cyc - t0 != 16) begin n_fail++; $display("FAIL b2b_rate: got %0d cycles for 16 bytes required 16", cyc - t0); end
        wait_words(exp_q.size());
        n_cmp++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL b2b_count: got %0d words required %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i].w !== exp_q[i].w || got_q[i].last !== exp_q[i].last || (exp_q[i].last && got_q[i].lwb !== exp_q[i].lwb)) begin
                n_fail++; $display("FAIL b2b_word%0d: got %h/%b/%0d required %h/%b/%0d", i, got_q[i].w, got_q[i].last, got_q[i].lwb, exp_q[i].w, exp_q[i].last, exp_q[i].lwb);
            end
        end
        pulse_finished();
        t0 = cyc;
        send_byte(8'h5A, 1'b1);
        n_cmp++; if (cyc - t0 != 1 || sm3_en_out !== 1'b1) begin n_fail++; $display("FAIL b2b_restart: cycles=%0d en=%b required 1/1", cyc - t0, sm3_en_out); end
        wait_words(exp_q.size() + 1);
        pulse_finished();
    endtask

    task automatic test_random();
        int len;
        rand_bp = 1'b1;
        for (int m = 0; m < 20; m++) begin
            clear_all();
            len = $urandom_range(1, 13);
            for (int i = 0; i < len; i++) msg_b.push_back(8'($urandom));
            model_msg();
            send_msg();
            wait_words(exp_q.size());
            n_cmp++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rnd%0d_count: got %0d words required %0d", m, got_q.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                n_cmp++;
                if (got_q[i].w !== exp_q[i].w || got_q[i].last !== exp_q[i].last || (exp_q[i].last && got_q[i].lwb !== exp_q[i].lwb)) begin
                    n_fail++; $display("FAIL rnd%0d_word%0d: got %h/%b/%0d required %h/%b/%0d", m, i, got_q[i].w, got_q[i].last, got_q[i].lwb, exp_q[i].w, exp_q[i].last, exp_q[i].lwb);
                end
            end
            n_cmp++; if (msg_len_out !== (32'(len) & LEN_MASK)) begin n_fail++; $display("FAIL rnd%0d_len: got %0d required %0d", m, msg_len_out, 32'(len) & LEN_MASK); end
            pulse_finished();
            n_cmp++; if (busy_out !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_idle: busy=%b required 0", m, busy_out); end
        end
        rand_bp = 1'b0;
        msg_ready_in = 1'b1;
    endtask

    initial begin
        reset_in        = 1'b1;
        byte_in         = 8'h0;
        byte_valid_in   = 1'b0;
        byte_last_in    = 1'b0;
        msg_ready_in    = 1'b0;
        sm3_finished_in = 1'b0;
        test_reset();
        test_abc();
        test_eight();
        test_backpressure();
        test_sticky_finished();
        test_reset_mid();
        test_drain_block();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
